// File: rtl/q2_pkg.sv
// -----------------------------------------------------------------------------
// q2_pkg
// Shared types and parameter defaults for the run_control block.
//   run_state_t             : control FSM states
//   DEFAULT_DEBOUNCE_CYCLES : consecutive identical samples to accept a level
//   DEFAULT_STEP_CLOCKS     : clk cycles run by one single step (one cdiv period)
// -----------------------------------------------------------------------------
package q2_pkg;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUN     = 2'd1,
      ST_STEP    = 2'd2,
      ST_HALTED  = 2'd3
   } run_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_STEP_CLOCKS     = 2;

   // RUN and STEP are the states in which the oscillator is released.
   function automatic logic is_active(run_state_t s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction

endpackage

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Two-flop synchronizer, level debouncer and rising-edge detector for one raw
// push button.
//   clk      : system clock
//   nreset   : synchronous active-low reset
//   btn_i    : raw button, active-high, asynchronous to clk
//   press_o  : one-clk pulse on each accepted (debounced) press
// -----------------------------------------------------------------------------
module debounce
   import q2_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic nreset,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_q, sync_q;
   logic          level_q, level_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of order.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         // The synchronizer presets to "pressed" so a button held through
         // reset can never look like a fresh release-then-press. The
         // debounced level itself starts released.
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= btn_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         armed_q <= armed_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal written here gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      level_d = level_q;
      armed_d = armed_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (!armed_q) begin
         // After reset, presses are reported only once the button has been
         // seen released for a full debounce window.
         if (!sync_q) begin
            if (cnt_q == CNT_LAST) armed_d = 1'b1;
            else                   cnt_d   = cnt_q + 1'b1;
         end
      end else if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            press_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/run_control.sv
// -----------------------------------------------------------------------------
// run_control
// Front-panel run/stop/single-step controller for a CPU clock oscillator.
//   clk        : system clock (only clock)
//   nreset     : synchronous active-low reset
//   btn_start  : raw run button, active-high, asynchronous
//   btn_stop   : raw stop button, active-high, asynchronous
//   btn_step   : raw single-step button, active-high, asynchronous
//   halt       : CPU halt request, synchronous, active-high
//   nstart     : one-clk active-low start pulse on entry to RUN or STEP
//   nstop      : active-low stop level, low in STOPPED and HALTED
//   cdiv/ncdiv : clock-divide phase and its complement
//   running    : high in RUN and STEP
//   cycle_count: (RUN_CONTROL_CYCLE_COUNT_EN only) 16-bit count of clk cycles
//                with nstop high, wrapping
// Optional feature macro: RUN_CONTROL_CYCLE_COUNT_EN
// -----------------------------------------------------------------------------
module run_control
   import q2_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int STEP_CLOCKS     = DEFAULT_STEP_CLOCKS
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        btn_start,
   input  logic        btn_stop,
   input  logic        btn_step,
   input  logic        halt,
   output logic        nstart,
   output logic        nstop,
   output logic        cdiv,
   output logic        ncdiv,
   output logic        running
`ifdef RUN_CONTROL_CYCLE_COUNT_EN
   ,
   output logic [15:0] cycle_count
`endif
);

   localparam int SCW = $clog2(STEP_CLOCKS + 1);
   localparam logic [SCW-1:0] STEP_LOAD = SCW'(STEP_CLOCKS);

   logic start_p, stop_p, step_p;

   run_state_t     state_q, state_d;
   logic [SCW-1:0] step_cnt_q, step_cnt_d;
   logic           nstart_q, nstart_d;
   logic           nstop_q, nstop_d;
   logic           cdiv_q, cdiv_d;
   logic           entry_cdiv_q, entry_cdiv_d;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk(clk), .nreset(nreset), .btn_i(btn_start), .press_o(start_p));
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
      .clk(clk), .nreset(nreset), .btn_i(btn_stop), .press_o(stop_p));
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
      .clk(clk), .nreset(nreset), .btn_i(btn_step), .press_o(step_p));

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q      <= ST_STOPPED;
         step_cnt_q   <= '0;
         nstart_q     <= 1'b1;
         nstop_q      <= 1'b0;
         cdiv_q       <= 1'b0;
         entry_cdiv_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_cnt_q   <= step_cnt_d;
         nstart_q     <= nstart_d;
         nstop_q      <= nstop_d;
         cdiv_q       <= cdiv_d;
         entry_cdiv_q <= entry_cdiv_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      step_cnt_d   = step_cnt_q;
      entry_cdiv_d = entry_cdiv_q;
      cdiv_d       = cdiv_q ^ nstop_q;

      // halt beats every press; among presses stop > step > start.
      unique case (state_q)
         ST_STOPPED: begin
            if (!halt && !stop_p) begin
               if (step_p)       state_d = ST_STEP;
               else if (start_p) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt)        state_d = ST_HALTED;
            else if (stop_p) state_d = ST_STOPPED;
         end
         ST_STEP: begin
            if (halt)                                   state_d    = ST_HALTED;
            else if (stop_p || step_cnt_q <= SCW'(1))   state_d    = ST_STOPPED;
            else                                        step_cnt_d = step_cnt_q - 1'b1;
         end
         ST_HALTED: begin
            // Leaving HALTED only clears the halt; a second press is
            // needed to run again.
            if (!halt && !stop_p && (start_p || step_p)) state_d = ST_STOPPED;
         end
         default: state_d = ST_STOPPED;
      endcase

      if (state_d == ST_STEP && state_q != ST_STEP) begin
         step_cnt_d   = STEP_LOAD;
         entry_cdiv_d = cdiv_q;
      end
      // A step, completed or aborted, always leaves cdiv where it started.
      if (state_q == ST_STEP && state_d != ST_STEP) begin
         step_cnt_d = '0;
         cdiv_d     = entry_cdiv_q;
      end

      nstart_d = !(is_active(state_d) && !is_active(state_q));
      nstop_d  = is_active(state_d);
   end

   assign nstart  = nstart_q;
   assign nstop   = nstop_q;
   assign cdiv    = cdiv_q;
   assign ncdiv   = ~cdiv_q;
   assign running = is_active(state_q);

`ifdef RUN_CONTROL_CYCLE_COUNT_EN
   logic [15:0] cycle_cnt_q;

   always_ff @(posedge clk) begin
      if (!nreset) cycle_cnt_q <= '0;
      else         cycle_cnt_q <= cycle_cnt_q + {15'd0, nstop_q};
   end

   assign cycle_count = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_run_control.sv
// -----------------------------------------------------------------------------
// tb_run_control
// Self-checking bench for run_control: directed scenarios followed by random
// button/halt/reset traffic, every cycle compared against a behavioural model.
// Define RUN_CONTROL_CYCLE_COUNT_EN to also exercise cycle_count.
// -----------------------------------------------------------------------------
module tb_run_control;
   import q2_pkg::*;

   localparam int DB = DEFAULT_DEBOUNCE_CYCLES;
   localparam int SC = DEFAULT_STEP_CLOCKS;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   logic btn_start = 1'b0, btn_stop = 1'b0, btn_step = 1'b0, halt = 1'b0;
   logic nstart, nstop, cdiv, ncdiv, running;
`ifdef RUN_CONTROL_CYCLE_COUNT_EN
   logic [15:0] cycle_count;
`endif

   always #5 clk = ~clk;

   run_control dut (
      .clk(clk), .nreset(nreset),
      .btn_start(btn_start), .btn_stop(btn_stop), .btn_step(btn_step),
      .halt(halt),
      .nstart(nstart), .nstop(nstop), .cdiv(cdiv), .ncdiv(ncdiv),
      .running(running)
`ifdef RUN_CONTROL_CYCLE_COUNT_EN
      , .cycle_count(cycle_count)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_FREE, M_SINGLE, M_HELD} mode_e;

   mode_e       mode;
   int          step_done;
   bit          m_nstart, m_nstop, m_cdiv, m_entry_cdiv;
   logic [15:0] m_cc;
   // Per button (0 start, 1 stop, 2 step): raw samples still in flight
   // through the synchronizer, debounced level, arming and run length.
   bit          dly [3][2];
   bit          b_level [3];
   bit          b_armed [3];
   int          b_streak [3];
   bit          b_press [3];

   function automatic bit active(mode_e m);
      return (m == M_FREE) || (m == M_SINGLE);
   endfunction

   task automatic model_reset();
      mode = M_IDLE; step_done = 0;
      m_nstart = 1'b1; m_nstop = 1'b0; m_cdiv = 1'b0; m_entry_cdiv = 1'b0;
      m_cc = '0;
      for (int b = 0; b < 3; b++) begin
         dly[b][0] = 1'b1; dly[b][1] = 1'b1;
         b_level[b] = 1'b0; b_armed[b] = 1'b0; b_streak[b] = 0; b_press[b] = 1'b0;
      end
   endtask

   task automatic model_edge(input bit rst_n, input bit [2:0] raw, input bit h);
      bit    ps, pp, pst, seen;
      mode_e nxt;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ps = b_press[0]; pp = b_press[1]; pst = b_press[2];
      nxt = mode;
      case (mode)
         M_IDLE:   if (!h && !pp) nxt = pst ? M_SINGLE : (ps ? M_FREE : M_IDLE);
         M_FREE:   if (h) nxt = M_HELD; else if (pp) nxt = M_IDLE;
         M_SINGLE: begin
            step_done++;
            if (h) nxt = M_HELD;
            else if (pp || step_done == SC) nxt = M_IDLE;
         end
         M_HELD:   if (!h && !pp && (ps || pst)) nxt = M_IDLE;
         default:  nxt = M_IDLE;
      endcase
      if (m_nstop) m_cc = m_cc + 16'd1;
      if (nxt == M_SINGLE && mode != M_SINGLE) begin
         step_done = 0;
         m_entry_cdiv = m_cdiv;
      end
      if (mode == M_SINGLE && nxt != M_SINGLE) m_cdiv = m_entry_cdiv;
      else if (m_nstop)                       m_cdiv = !m_cdiv;
      m_nstart = !(active(nxt) && !active(mode));
      m_nstop  = active(nxt);
      mode     = nxt;
      for (int b = 0; b < 3; b++) begin
         seen = dly[b][1];
         dly[b][1] = dly[b][0];
         dly[b][0] = raw[b];
         b_press[b] = 1'b0;
         if (!b_armed[b]) begin
            if (!seen) begin
               b_streak[b]++;
               if (b_streak[b] == DB) begin b_armed[b] = 1'b1; b_streak[b] = 0; end
            end else b_streak[b] = 0;
         end else if (seen != b_level[b]) begin
            b_streak[b]++;
            if (b_streak[b] == DB) begin
               b_level[b] = seen; b_press[b] = seen; b_streak[b] = 0;
            end
         end else b_streak[b] = 0;
      end
   endtask

   // ---------------- cycle driver ----------------
   int pulses;      // nstart low cycles seen since last clear
   int nstop_high;  // nstop high cycles seen since last clear

   task automatic tick();
      @(posedge clk);
      model_edge(nreset, {btn_step, btn_stop, btn_start}, halt);
      @(negedge clk);
      check("nstart",  nstart,  m_nstart);
      check("nstop",   nstop,   m_nstop);
      check("cdiv",    cdiv,    m_cdiv);
      check("ncdiv",   ncdiv,   !m_cdiv);
      check("running", running, active(mode));
`ifdef RUN_CONTROL_CYCLE_COUNT_EN
      check("cycle_count", cycle_count, m_cc);
`endif
      if (nstart === 1'b0) pulses++;
      if (nstop  === 1'b1) nstop_high++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Hold one button (0 start, 1 stop, 2 step) then release and let it settle.
   task automatic press(input int idx, input int hold);
      if (idx == 0) btn_start = 1'b1;
      if (idx == 1) btn_stop  = 1'b1;
      if (idx == 2) btn_step  = 1'b1;
      ticks(hold);
      btn_start = 1'b0; btn_stop = 1'b0; btn_step = 1'b0;
      ticks(DB + 4);
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      ticks(2);
      nreset = 1'b1;
      ticks(DB + 4);
   endtask

   logic [3:0] seq;
   logic       cdiv_before;
   int         waited;

   initial begin
      model_reset();
      // Reset state.
      nreset = 1'b0;
      ticks(3);
      check("rst_nstart",  nstart,  1'b1);
      check("rst_nstop",   nstop,   1'b0);
      check("rst_cdiv",    cdiv,    1'b0);
      check("rst_ncdiv",   ncdiv,   1'b1);
      check("rst_running", running, 1'b0);
      nreset = 1'b1;
      ticks(DB + 4);

      // Start held: one pulse, nstop high, cdiv 0,1,0,1.
      pulses = 0;
      btn_start = 1'b1;
      waited = 0;
      while (!m_nstop && waited < 20) begin tick(); waited++; end
      check("run_entry_timeout", (waited < 20), 1'b1);
      seq = {3'b000, cdiv};
      for (int i = 0; i < 3; i++) begin tick(); seq = {seq[2:0], cdiv}; end
      check("run_cdiv_seq", seq, 4'b0101);
      btn_start = 1'b0;
      ticks(DB + 4);
      check("run_pulses", pulses, 1);
      check("run_nstop",  nstop,  1'b1);
      press(1, DB + 3);
      check("stop_nstop", nstop, 1'b0);

      // Single step: nstop high exactly SC cycles, cdiv restored.
      cdiv_before = cdiv;
      pulses = 0; nstop_high = 0;
      press(2, DB + 3);
      check("step_len",     nstop_high, SC);
      check("step_pulses",  pulses,     1);
      check("step_cdiv",    cdiv,       cdiv_before);
      check("step_stopped", running,    1'b0);

      // Halt from RUN, first start only clears it, second one runs.
      press(0, DB + 3);
      halt = 1'b1; tick(); halt = 1'b0; tick();
      check("halt_nstop", nstop, 1'b0);
      pulses = 0;
      press(0, DB + 3);
      check("halt_clear_pulses", pulses, 0);
      check("halt_clear_nstop",  nstop,  1'b0);
      press(0, DB + 3);
      check("halt_rerun_pulses", pulses, 1);
      check("halt_rerun_nstop",  nstop,  1'b1);
      press(1, DB + 3);

      // Bounce 1-0-1 shorter than the debounce window: nothing happens.
      pulses = 0;
      btn_start = 1'b1; ticks(2);
      btn_start = 1'b0; ticks(1);
      btn_start = 1'b1; ticks(1);
      btn_start = 1'b0; ticks(DB + 6);
      check("bounce_pulses", pulses, 0);
      check("bounce_nstop",  nstop,  1'b0);

      // Start and stop together while stopped: stop wins.
      pulses = 0;
      btn_start = 1'b1; btn_stop = 1'b1;
      ticks(DB + 4);
      btn_start = 1'b0; btn_stop = 1'b0;
      ticks(DB + 4);
      check("both_pulses", pulses, 0);
      check("both_nstop",  nstop,  1'b0);

      // Reset mid-run with start held through it: no pulse, no restart.
      press(0, DB + 3);
      pulses = 0;
      btn_start = 1'b1;
      nreset = 1'b0; ticks(3);
      nreset = 1'b1; ticks(3 * DB + 6);
      check("held_rst_pulses", pulses, 0);
      check("held_rst_nstop",  nstop,  1'b0);
      btn_start = 1'b0;
      ticks(DB + 4);
      press(0, DB + 3);
      check("fresh_press_nstop", nstop, 1'b1);
      press(1, DB + 3);

      // Random traffic.
      for (int seg = 0; seg < 400; seg++) begin
         btn_start = ($urandom_range(0, 2) == 0);
         btn_stop  = ($urandom_range(0, 3) == 0);
         btn_step  = ($urandom_range(0, 2) == 0);
         halt      = ($urandom_range(0, 7) == 0);
         nreset    = ($urandom_range(0, 49) != 0);
         ticks($urandom_range(1, 10));
         nreset = 1'b1;
      end
      btn_start = 1'b0; btn_stop = 1'b0; btn_step = 1'b0; halt = 1'b0;
      ticks(DB + 4);

`ifdef RUN_CONTROL_CYCLE_COUNT_EN
      // Long run: 70000 clk with nstop high wraps to 4464.
      do_reset();
      btn_start = 1'b1;
      waited = 0;
      while (!m_nstop && waited < 20) begin tick(); waited++; end
      check("cc_entry_timeout", (waited < 20), 1'b1);
      btn_start = 1'b0;
      check("cc_start", cycle_count, 16'd0);
      ticks(70000);
      check("cc_70000", cycle_count, 16'd4464);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical samples needed to accept a button level change.
REQ-002 Parameter STEP_CLOCKS, default 2: clk cycles run per single step, equal to one full cdiv period.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 nreset  input  1  reset; synchronous, active-low.
REQ-005 btn_start  input  1  raw run button, active-high, asynchronous to clk.
REQ-006 btn_stop  input  1  raw stop button, active-high, asynchronous to clk.
REQ-007 btn_step  input  1  raw single-step button, active-high, asynchronous to clk.
REQ-008 halt  input  1  CPU halt request, synchronous, active-high.
REQ-009 nstart  output  1  one-clk active-low start pulse to the oscillator.
REQ-010 nstop  output  1  active-low stop level to the oscillator; low while stopped.
REQ-011 cdiv  output  1  clock-divide phase; toggles every clk while running.
REQ-012 ncdiv  output  1  always the complement of cdiv.
REQ-013 running  output  1  high in RUN and STEP states.

Function
REQ-014 Each button passes a 2-flop synchronizer, then a debouncer; a press event is the debounced rising edge, one clk wide.
REQ-015 States SHALL be STOPPED, RUN, STEP, HALTED.
REQ-016 STOPPED: start press -> RUN; step press -> STEP; other presses ignored.
REQ-017 RUN: stop press or halt -> STOPPED (halt -> HALTED); start and step presses ignored.
REQ-018 STEP: runs exactly STEP_CLOCKS clk cycles, then -> STOPPED; stop press or halt mid-step aborts immediately to STOPPED or HALTED.
REQ-019 HALTED: start or step press -> STOPPED only (first clears halt; second press needed to run).
REQ-020 Simultaneous presses in one cycle: stop > step > start priority; halt overrides all presses.
REQ-021 nstart SHALL pulse low for exactly one clk on every entry into RUN or STEP, registered, in the cycle after the transition.
REQ-022 nstop SHALL be low in STOPPED and HALTED, high in RUN and STEP, registered, changing in the same cycle as nstart.
REQ-023 cdiv toggles every clk only while nstop is high; holds its value when stopped; STEP always ends with cdiv back at its entry value.
REQ-024 Step counter width SHALL be clog2(STEP_CLOCKS+1); count reloads on each STEP entry, no wrap.

Reset
REQ-025 nreset low at a clk edge: state STOPPED, nstart=1, nstop=0, cdiv=0, ncdiv=1, running=0, debouncers cleared to released, counters 0.
REQ-026 Reset mid-RUN or mid-STEP SHALL produce no nstart pulse; buttons held through reset release require a fresh press.

Configuration
REQ-027 Macro RUN_CONTROL_CYCLE_COUNT_EN: when defined, adds output cycle_count (16 bits), cleared on reset, +1 per clk with nstop high, wraps 0xFFFF->0x0000; when undefined, port and counter absent, all else identical.

Structure
REQ-028 Package q2_pkg holds the run_state_t enum and DEBOUNCE_CYCLES/STEP_CLOCKS defaults.
REQ-029 One sub-module, debounce (synchronizer + counter + edge detect), instantiated three times.

Verification
REQ-030 Reset, then start held 4+ clk -> one nstart low pulse, nstop high, cdiv toggles 0,1,0,1.
REQ-031 STOPPED, step press -> nstop high exactly 2 clk, one nstart pulse, cdiv returns to 0, state STOPPED.
REQ-032 RUN, halt=1 -> HALTED next cycle, nstop low; start press -> STOPPED, no nstart; second start -> RUN.
REQ-033 Button bounce 1-0-1 shorter than 4 clk -> no press event, no output change.
REQ-034 start and stop press same cycle in STOPPED -> stays STOPPED, nstart stays 1.
REQ-035 With RUN_CONTROL_CYCLE_COUNT_EN, 70000 clk in RUN -> cycle_count = 70000 mod 65536 = 4464.
